// File: rtl/switcher_sequence_decoder.sv
// Decodes the 4x-oversampled switcher control word into frame/row events with
// per-row GATE/CLEAR high-time, plus sticky protocol-violation flags.
module switcher_sequence_decoder #(
  parameter int N_ROWS      = 192,
  parameter int ROW_W       = 8,
  parameter int WIDTH_W     = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               CLK_80,
  input  logic               RESET_N,
  input  logic [15:0]        SW_DES,
  input  logic               ERR_CLEAR,
  output logic               FRAME_START,
  output logic               ROW_VALID,
  output logic [ROW_W-1:0]   ROW,
  output logic [1:0]         ROW_PHASE,
  output logic [WIDTH_W-1:0] GATE_WIDTH,
  output logic [WIDTH_W-1:0] CLEAR_WIDTH,
  output logic               IN_FRAME,
  output logic [15:0]        FRAME_COUNT,
  output logic               GLITCH_ERR,
  output logic               TIMEOUT_ERR,
  output logic               ROW_OVF_ERR,
  output logic               FRAME_LEN_ERR
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(N_ROWS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W:0]   N_ROWS_V   = (ROW_W + 1)'(N_ROWS);
  localparam logic [WD_W-1:0]  WD_ONE     = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]  TIMEOUT_V  = WD_W'(TIMEOUT_CYC);

  typedef enum logic {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [3:0]           prev_r;
  logic [ROW_W-1:0]     row_cnt_r, row_cnt_s;
  logic [ROW_W:0]       row_inc_s;
  logic [WIDTH_W-1:0]   gate_cnt_r, gate_cnt_s, clr_cnt_r, clr_cnt_s;
  logic [WIDTH_W-1:0]   gate_closed_s, clr_closed_s;
  logic [WD_W-1:0]      wd_r, wd_s, wd_inc_s;
  logic [3:0]           clk_smp_s, frm_smp_s, clr_smp_s, gat_smp_s;
  logic [3:0]           rise_s, old_mask_s, new_mask_s;
  logic [1:0]           phase_s;
  logic                 edge_s, fs_edge_s, glitch_s;
  logic                 rv_s, fs_s, len_set_s, ovf_set_s, to_set_s;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    pop4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [WIDTH_W-1:0] sat_add(input logic [WIDTH_W-1:0] a,
                                                 input logic [2:0] b);
    logic [WIDTH_W:0] sum;
    sum = {1'b0, a} + {{(WIDTH_W-2){1'b0}}, b};
    if (sum[WIDTH_W]) sat_add = {WIDTH_W{1'b1}};
    else              sat_add = sum[WIDTH_W-1:0];
  endfunction

  // Sample unpacking, SW_CLK rising-edge search and old/new row sample split
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      clk_smp_s[k] = SW_DES[4*k];
      frm_smp_s[k] = SW_DES[4*k+1];
      clr_smp_s[k] = SW_DES[4*k+2];
      gat_smp_s[k] = SW_DES[4*k+3];
    end
    rise_s   = clk_smp_s & ~{clk_smp_s[2:0], prev_r[0]};
    edge_s   = |rise_s;
    glitch_s = (rise_s & (rise_s - 4'b0001)) != 4'b0000;
    if      (rise_s[0]) phase_s = 2'd0;
    else if (rise_s[1]) phase_s = 2'd1;
    else if (rise_s[2]) phase_s = 2'd2;
    else if (rise_s[3]) phase_s = 2'd3;
    else                phase_s = 2'd0;
    case (phase_s)
      2'd0:    old_mask_s = 4'b0000;
      2'd1:    old_mask_s = 4'b0001;
      2'd2:    old_mask_s = 4'b0011;
      2'd3:    old_mask_s = 4'b0111;
      default: old_mask_s = 4'b0000;
    endcase
    new_mask_s = ~old_mask_s;
    fs_edge_s  = edge_s & frm_smp_s[phase_s];
  end

  // Frame/row state machine; without an edge the whole word joins the open row
  always_comb begin
    state_s       = state_r;
    row_cnt_s     = row_cnt_r;
    row_inc_s     = {1'b0, row_cnt_r} + {1'b0, ROW_ONE};
    wd_inc_s      = wd_r + WD_ONE;
    wd_s          = wd_r;
    gate_closed_s = sat_add(gate_cnt_r, pop4(gat_smp_s & old_mask_s));
    clr_closed_s  = sat_add(clr_cnt_r, pop4(clr_smp_s & old_mask_s));
    gate_cnt_s    = sat_add(gate_cnt_r, pop4(gat_smp_s & new_mask_s));
    clr_cnt_s     = sat_add(clr_cnt_r, pop4(clr_smp_s & new_mask_s));
    rv_s          = 1'b0;
    fs_s          = 1'b0;
    len_set_s     = 1'b0;
    ovf_set_s     = 1'b0;
    to_set_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        wd_s = {WD_W{1'b0}};
        if (fs_edge_s) begin
          state_s    = ST_FRAME;
          row_cnt_s  = {ROW_W{1'b0}};
          gate_cnt_s = {{(WIDTH_W-3){1'b0}}, pop4(gat_smp_s & new_mask_s)};
          clr_cnt_s  = {{(WIDTH_W-3){1'b0}}, pop4(clr_smp_s & new_mask_s)};
          fs_s       = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (edge_s) begin
          rv_s       = 1'b1;
          wd_s       = {WD_W{1'b0}};
          gate_cnt_s = {{(WIDTH_W-3){1'b0}}, pop4(gat_smp_s & new_mask_s)};
          clr_cnt_s  = {{(WIDTH_W-3){1'b0}}, pop4(clr_smp_s & new_mask_s)};
          if (fs_edge_s) begin
            fs_s      = 1'b1;
            row_cnt_s = {ROW_W{1'b0}};
            len_set_s = (row_cnt_r != LAST_ROW);
          end else if (row_cnt_r == LAST_ROW) begin
            state_s = ST_IDLE;
          end else if (row_inc_s >= N_ROWS_V) begin
            ovf_set_s = 1'b1;
            state_s   = ST_IDLE;
          end else begin
            row_cnt_s = row_inc_s[ROW_W-1:0];
          end
        end else if (wd_inc_s == TIMEOUT_V) begin
          to_set_s = 1'b1;
          wd_s     = {WD_W{1'b0}};
          state_s  = ST_IDLE;
        end else begin
          wd_s = wd_inc_s;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counters, registered event outputs and sticky error flags
  always_ff @(posedge CLK_80 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      prev_r        <= 4'b1111;
      row_cnt_r     <= {ROW_W{1'b0}};
      gate_cnt_r    <= {WIDTH_W{1'b0}};
      clr_cnt_r     <= {WIDTH_W{1'b0}};
      wd_r          <= {WD_W{1'b0}};
      FRAME_START   <= 1'b0;
      ROW_VALID     <= 1'b0;
      ROW           <= {ROW_W{1'b0}};
      ROW_PHASE     <= 2'd0;
      GATE_WIDTH    <= {WIDTH_W{1'b0}};
      CLEAR_WIDTH   <= {WIDTH_W{1'b0}};
      IN_FRAME      <= 1'b0;
      FRAME_COUNT   <= 16'd0;
      GLITCH_ERR    <= 1'b0;
      TIMEOUT_ERR   <= 1'b0;
      ROW_OVF_ERR   <= 1'b0;
      FRAME_LEN_ERR <= 1'b0;
    end else begin
      state_r       <= state_s;
      prev_r        <= SW_DES[15:12];
      row_cnt_r     <= row_cnt_s;
      gate_cnt_r    <= gate_cnt_s;
      clr_cnt_r     <= clr_cnt_s;
      wd_r          <= wd_s;
      FRAME_START   <= fs_s;
      ROW_VALID     <= rv_s;
      if (rv_s) begin
        ROW         <= row_cnt_r;
        ROW_PHASE   <= phase_s;
        GATE_WIDTH  <= gate_closed_s;
        CLEAR_WIDTH <= clr_closed_s;
      end
      IN_FRAME      <= (state_s == ST_FRAME);
      FRAME_COUNT   <= FRAME_COUNT + {15'd0, fs_s};
      // a new error in the same cycle as ERR_CLEAR must survive
      GLITCH_ERR    <= (GLITCH_ERR    & ~ERR_CLEAR) | glitch_s;
      TIMEOUT_ERR   <= (TIMEOUT_ERR   & ~ERR_CLEAR) | to_set_s;
      ROW_OVF_ERR   <= (ROW_OVF_ERR   & ~ERR_CLEAR) | ovf_set_s;
      FRAME_LEN_ERR <= (FRAME_LEN_ERR & ~ERR_CLEAR) | len_set_s;
    end
  end

endmodule

// File: tb/tb_switcher_sequence_decoder.sv
// Directed bench for switcher_sequence_decoder; row/frame events are predicted
// into queues when a word is driven and popped when the DUT pulses.
module tb_switcher_sequence_decoder;

  typedef struct packed {
    logic [7:0] row;
    logic [1:0] phase;
    logic [7:0] gate;
    logic [7:0] clear;
  } row_exp_t;

  logic        CLK_80 = 1'b0;
  logic        RESET_N;
  logic [15:0] SW_DES;
  logic        ERR_CLEAR;
  logic        FRAME_START, ROW_VALID, IN_FRAME;
  logic [7:0]  ROW, GATE_WIDTH, CLEAR_WIDTH;
  logic [1:0]  ROW_PHASE;
  logic [15:0] FRAME_COUNT;
  logic        GLITCH_ERR, TIMEOUT_ERR, ROW_OVF_ERR, FRAME_LEN_ERR;

  row_exp_t    rq[$];
  logic [15:0] fq[$];
  int          total = 0;
  int          bad   = 0;

  switcher_sequence_decoder dut (
    .CLK_80(CLK_80), .RESET_N(RESET_N), .SW_DES(SW_DES), .ERR_CLEAR(ERR_CLEAR),
    .FRAME_START(FRAME_START), .ROW_VALID(ROW_VALID), .ROW(ROW),
    .ROW_PHASE(ROW_PHASE), .GATE_WIDTH(GATE_WIDTH), .CLEAR_WIDTH(CLEAR_WIDTH),
    .IN_FRAME(IN_FRAME), .FRAME_COUNT(FRAME_COUNT), .GLITCH_ERR(GLITCH_ERR),
    .TIMEOUT_ERR(TIMEOUT_ERR), .ROW_OVF_ERR(ROW_OVF_ERR),
    .FRAME_LEN_ERR(FRAME_LEN_ERR)
  );

  always #5 CLK_80 = ~CLK_80;

  // Arguments are per-signal sample vectors, bit k = sample k (0 oldest)
  function automatic logic [15:0] mk(input logic [3:0] c, input logic [3:0] f,
                                     input logic [3:0] cl, input logic [3:0] g);
    logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w[4*k]   = c[k];
      w[4*k+1] = f[k];
      w[4*k+2] = cl[k];
      w[4*k+3] = g[k];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_row(input int r, input int ph, input int g, input int cl);
    row_exp_t e;
    e.row = 8'(r); e.phase = 2'(ph); e.gate = 8'(g); e.clear = 8'(cl);
    rq.push_back(e);
  endtask

  // Drive one word, then score the registered outputs one cycle later
  task automatic step(input logic [15:0] w);
    row_exp_t    e;
    logic [15:0] fc;
    @(negedge CLK_80);
    SW_DES = w;
    @(posedge CLK_80);
    #1;
    chk("row_valid", 64'(ROW_VALID), 64'(rq.size() > 0));
    if (ROW_VALID && rq.size() > 0) begin
      e = rq.pop_front();
      chk("row_data", 64'({ROW, ROW_PHASE, GATE_WIDTH, CLEAR_WIDTH}), 64'(e));
    end
    chk("frame_start", 64'(FRAME_START), 64'(fq.size() > 0));
    if (FRAME_START && fq.size() > 0) begin
      fc = fq.pop_front();
      chk("frame_count", 64'(FRAME_COUNT), 64'(fc));
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({FRAME_START, ROW_VALID, ROW, ROW_PHASE, GATE_WIDTH, CLEAR_WIDTH,
                IN_FRAME, FRAME_COUNT, GLITCH_ERR, TIMEOUT_ERR, ROW_OVF_ERR,
                FRAME_LEN_ERR});
  endfunction

  initial begin
    logic [15:0] w_zero, w_e, w_w1, w_e2, w_fe;
    w_zero = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    w_e    = mk(4'b0011, 4'b0000, 4'b0000, 4'b1111);
    w_w1   = mk(4'b0000, 4'b0000, 4'b0000, 4'b1111);
    w_e2   = mk(4'b0011, 4'b0000, 4'b0000, 4'b0000);
    w_fe   = mk(4'b0011, 4'b0001, 4'b0000, 4'b0000);

    RESET_N = 1'b0; SW_DES = 16'hFFFF; ERR_CLEAR = 1'b0;
    repeat (3) @(negedge CLK_80);
    chk("reset_outputs", all_outs(), 64'd0);
    RESET_N = 1'b1;

    // All-ones word at reset release: no edge because prev resets high
    repeat (10) step(16'hFFFF);
    chk("idle_after_ones", 64'({IN_FRAME, GLITCH_ERR, TIMEOUT_ERR, ROW_OVF_ERR, FRAME_LEN_ERR}), 64'd0);

    // Full 192-row frame, start edge at k=2, GATE 8 samples per row
    step(w_zero);
    fq.push_back(16'd1);
    step(mk(4'b1100, 4'b0100, 4'b0000, 4'b1111));
    chk("in_frame_start", 64'(IN_FRAME), 64'd1);
    step(mk(4'b0000, 4'b0000, 4'b0000, 4'b1111));
    step(mk(4'b0000, 4'b0000, 4'b0000, 4'b0011));
    for (int r = 0; r < 192; r++) begin
      push_row(r, 0, 8, 0);
      step(w_e);
      step(w_w1);
    end
    chk("in_frame_end", 64'(IN_FRAME), 64'd0);
    chk("frame_count_1", 64'(FRAME_COUNT), 64'd1);
    chk("no_err_frame1", 64'({GLITCH_ERR, TIMEOUT_ERR, ROW_OVF_ERR, FRAME_LEN_ERR}), 64'd0);

    // Plain CLK edge in IDLE is ignored
    step(w_e);
    step(w_zero);

    // Second frame: edge at k=3 splits CLEAR between rows
    fq.push_back(16'd2);
    step(w_fe);
    step(mk(4'b0000, 4'b0000, 4'b1111, 4'b0000));
    push_row(0, 3, 0, 6);
    step(mk(4'b1000, 4'b0000, 4'b1110, 4'b0000));
    step(w_zero);
    push_row(1, 1, 0, 1);
    step(mk(4'b0110, 4'b0000, 4'b0000, 4'b0000));
    for (int r = 2; r < 99; r++) begin
      step(w_w1);
      push_row(r, 0, 4, 0);
      step(w_e2);
    end
    step(w_w1);
    // New FRAME edge closes row 99 early
    push_row(99, 0, 4, 0);
    fq.push_back(16'd3);
    step(w_fe);
    chk("frame_len_err_set", 64'(FRAME_LEN_ERR), 64'd1);
    chk("in_frame_restart", 64'(IN_FRAME), 64'd1);
    ERR_CLEAR = 1'b1;
    step(w_w1);
    chk("frame_len_err_clr", 64'(FRAME_LEN_ERR), 64'd0);

    // Two rising edges in one word with ERR_CLEAR held: error wins, lowest edge used
    push_row(0, 1, 5, 0);
    step(mk(4'b1010, 4'b0000, 4'b0000, 4'b1111));
    ERR_CLEAR = 1'b0;
    chk("glitch_err", 64'(GLITCH_ERR), 64'd1);

    // Watchdog: no CLK edges for TIMEOUT_CYC cycles
    repeat (4090) step(w_zero);
    chk("pre_timeout", 64'({IN_FRAME, TIMEOUT_ERR}), 64'b10);
    repeat (10) step(w_zero);
    chk("timeout_err", 64'(TIMEOUT_ERR), 64'd1);
    chk("timeout_idle", 64'(IN_FRAME), 64'd0);
    chk("glitch_sticky", 64'(GLITCH_ERR), 64'd1);

    // Async reset in the middle of a frame
    fq.push_back(16'd4);
    step(mk(4'b1111, 4'b1111, 4'b0000, 4'b0000));
    step(w_w1);
    chk("pre_reset_frame", 64'({IN_FRAME, FRAME_COUNT}), 64'({1'b1, 16'd4}));
    #2 RESET_N = 1'b0;
    #1;
    chk("async_reset", all_outs(), 64'd0);
    rq.delete();
    fq.delete();
    SW_DES = w_zero;
    repeat (2) @(negedge CLK_80);
    RESET_N = 1'b1;
    step(w_zero);
    step(w_e);
    step(w_zero);
    chk("post_reset_idle", 64'({IN_FRAME, FRAME_COUNT}), 64'd0);
    chk("queues_drained", 64'(rq.size() + fq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switcher_sequence_decoder.md
Name: switcher_sequence_decoder

Overview:
- Consumes the 320 MS/s oversampled switcher control word (4 samples per CLK_80 cycle of SW_GATE, SW_CLEAR, SW_FRAME and SW_CLK) produced by the switcher deserializer in the DCD emulator I/O layer.
- Reconstructs the DHP-generated switcher sequence: frame starts, row (gate) index, and per-row GATE/CLEAR high-time in 3.125 ns samples.
- Flags protocol violations so the emulator core can check DHP switcher timing against the digitized rows it serializes back.

Parameters:
- N_ROWS, 192, number of CLK edges (rows) in a complete frame.
- ROW_W, 8, width of the row index; must satisfy 2^ROW_W >= N_ROWS.
- WIDTH_W, 8, width of the GATE/CLEAR sample counters; counters saturate at 2^WIDTH_W-1.
- TIMEOUT_CYC, 4096, number of CLK_80 cycles allowed without an SW_CLK rising edge while in a frame.

Ports:
- CLK_80  in  1  80 MHz system clock, same domain as the deserializer outputs.
- RESET_N  in  1  asynchronous, active-low reset.
- SW_DES  in  16  oversampled word. Bit 4*k+i is sample k (k=0 oldest … 3 newest) of signal i (0=CLK, 1=FRAME, 2=CLEAR, 3=GATE).
- ERR_CLEAR  in  1  synchronous clear of the sticky error flags.
- FRAME_START  out  1  one-cycle pulse when a frame-start edge is decoded.
- ROW_VALID  out  1  one-cycle pulse when a row closes.
- ROW  out  ROW_W  index of the closed row; held between pulses.
- ROW_PHASE  out  2  sample index k of the edge that closed the row.
- GATE_WIDTH  out  WIDTH_W  GATE-high sample count for the closed row.
- CLEAR_WIDTH  out  WIDTH_W  CLEAR-high sample count for the closed row.
- IN_FRAME  out  1  high while in state FRAME.
- FRAME_COUNT  out  16  number of frame starts, wraps modulo 2^16.
- GLITCH_ERR  out  1  sticky error flag.
- TIMEOUT_ERR  out  1  sticky error flag.
- ROW_OVF_ERR  out  1  sticky error flag.
- FRAME_LEN_ERR  out  1  sticky error flag.

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE.
  - The previous-sample register for each signal resets to 1, so a signal already high at reset release does not produce a spurious rising edge.
- Edge detection, per cycle:
  - Build the 5-sample sequence {prev, s0, s1, s2, s3}.
  - A rising edge at k means s[k]=1 and s[k-1]=0.
  - The edge used is the lowest such k (ROW_PHASE = k).
  - More than one SW_CLK rising edge in one word sets GLITCH_ERR; the lowest edge is still used.
  - prev is updated to s3 every cycle.
- Frame-start edge: an SW_CLK rising edge at sample k where FRAME sample k = 1.
- Width accounting:
  - Samples with index < k belong to the row being closed.
  - Samples with index >= k belong to the new row.
  - GATE/CLEAR counters add the popcount of the high samples in the relevant range.
  - Counters saturate and never wrap.
- States:
  - IDLE: ignores SW_CLK edges without FRAME. On a frame-start edge: go to FRAME; row counter = 0; width counters load the new-row portion; FRAME_START pulses; FRAME_COUNT increments.
  - FRAME, on a plain SW_CLK edge:
    - ROW_VALID pulses, with ROW = current row and the widths including the old-row portion of the current word.
    - The row counter then increments.
    - If the closed row is N_ROWS-1, go to IDLE with FRAME_LEN_ERR unchanged; that is normal frame end.
    - An edge arriving in IDLE after a normal end without FRAME is ignored.
  - FRAME, on a frame-start edge:
    - Closes the open row (ROW_VALID), then restarts at row 0 with FRAME_START in the same cycle.
    - FRAME_LEN_ERR is set if the closed row index is not N_ROWS-1.
  - FRAME, row counter reaching N_ROWS without an intervening FRAME: set ROW_OVF_ERR and go to IDLE.
  - FRAME, timeout: the watchdog counter resets on every SW_CLK edge. When it reaches TIMEOUT_CYC, set TIMEOUT_ERR and go to IDLE without ROW_VALID.
- Latency: FRAME_START, ROW_VALID and the associated data are registered and appear exactly 1 CLK_80 cycle after the cycle in which the edge is on SW_DES.
- Error flags: sticky. ERR_CLEAR clears them the following cycle. If ERR_CLEAR and a new error occur in the same cycle, the error wins.
- Async reset mid-frame: returns to IDLE immediately and restores all reset values. No ROW_VALID is emitted for the open row.

Test Plan:
- Reset release with all SW_DES bits at 1 for 10 cycles -> no FRAME_START, no ROW_VALID, all error flags 0.
- Frame start with CLK edge at k=2 and FRAME=1, then 192 CLK edges each at k=0 with GATE high for 8 samples per row -> 192 ROW_VALID pulses with ROW 0..191, GATE_WIDTH=8, FRAME_COUNT=1, IN_FRAME=0 after row 191, no errors.
- Edge at k=3 with CLEAR high on samples 1..3 of the closing word -> ROW_PHASE=3 and CLEAR_WIDTH includes 2 samples from that word; sample 3 is counted in the next row.
- New FRAME edge after row 99 -> ROW_VALID with ROW=99, FRAME_START in the same cycle, FRAME_LEN_ERR=1; ERR_CLEAR then drops it to 0 the next cycle.
- Word with CLK pattern 0101 (two rising edges) -> GLITCH_ERR=1 and ROW_PHASE=1.
- Frame started, then no CLK edges for 4096 cycles -> TIMEOUT_ERR=1, IN_FRAME=0, no ROW_VALID. Asserting RESET_N=0 mid-frame instead -> all outputs 0 asynchronously.
